// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel/line counters, registered sync/blank decode,
// frame start pulse and frame counter. Define VGA_SYNC_DELAY_EN to lag hs/vs/blank by one cycle.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       fs_q, fs_d;
    logic [7:0] fcnt_q, fcnt_d;

    // Decode works on the next counter values so the registered flags line up
    // with the registered coordinates.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
        hs_d    = !((x_d >= HS_BEG) && (x_d < HS_END));
        vs_d    = !((y_d >= VS_BEG) && (y_d < VS_END));
        blank_d = (x_d < H_VIS) && (y_d < V_VIS);
        fs_d    = (x_d == '0) && (y_d == '0);
        fcnt_d  = fs_d ? fcnt_q + 8'd1 : fcnt_q;
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

`ifdef VGA_SYNC_DELAY_EN
    // Extra stage matches the renderers' registered colour path.
    logic hs_dly_q, vs_dly_q, blank_dly_q;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hs_dly_q    <= 1'b1;
            vs_dly_q    <= 1'b1;
            blank_dly_q <= 1'b0;
        end else begin
            hs_dly_q    <= hs_q;
            vs_dly_q    <= vs_q;
            blank_dly_q <= blank_q;
        end
    end

    assign hs    = hs_dly_q;
    assign vs    = vs_dly_q;
    assign blank = blank_dly_q;
`else
    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line/pixel timing and a
// shrunken instance for frame, frame-counter wrap and vsync behaviour.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic [7:0] fc;
    } vout_t;

    // Small geometry: 15 pixels x 13 lines = 195 cycles per frame.
    localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVV = 6, BVF = 2, BVS = 2, BVB = 3;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a_n, rst_b_n;
    logic [9:0] ax, ay, bx, by;
    logic ahs, avs, abl, afs, bhs, bvs, bbl, bfs;
    logic [7:0] afc, bfc;

    vga_timing_gen u_a (
        .vga_clk(clk), .reset_n(rst_a_n), .DrawX(ax), .DrawY(ay), .hs(ahs), .vs(avs),
        .blank(abl), .frame_start(afs), .frame_cnt(afc)
    );

    vga_timing_gen #(
        .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
    ) u_b (
        .vga_clk(clk), .reset_n(rst_b_n), .DrawX(bx), .DrawY(by), .hs(bhs), .vs(bvs),
        .blank(bbl), .frame_start(bfs), .frame_cnt(bfc)
    );

    int checks = 0;
    int errors = 0;

    // Model state: -2 unknown, -1 held in reset, n>0 = edges since reset release.
    int s_a = -2, sd_a = -2, s_b = -2, sd_b = -2;

    // Outputs as a pure function of elapsed cycles since reset release.
    function automatic vout_t model(int s, int hv, int hf, int hw, int hb,
                                    int vv, int vf, int vw, int vb);
        vout_t o;
        int ht, vt, ft, p, x, y;
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        ft = ht * vt;
        if (s < 0) begin
            o = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, fc: 8'd0};
            return o;
        end
        p = s % ft;
        x = p % ht;
        y = p / ht;
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.hs    = !(x >= hv + hf && x < hv + hf + hw);
        o.vs    = !(y >= vv + vf && y < vv + vf + vw);
        o.blank = (x < hv) && (y < vv);
        o.fs    = (p == 0);
        o.fc    = 8'((s / ft) % 256);
        return o;
    endfunction

    function automatic vout_t expect_out(int s, int sd, int hv, int hf, int hw, int hb,
                                         int vv, int vf, int vw, int vb);
        vout_t e;
        e = model(s, hv, hf, hw, hb, vv, vf, vw, vb);
`ifdef VGA_SYNC_DELAY_EN
        begin
            vout_t d;
            d = model(sd, hv, hf, hw, hb, vv, vf, vw, vb);
            e.hs    = d.hs;
            e.vs    = d.vs;
            e.blank = d.blank;
        end
`endif
        return e;
    endfunction

    always @(posedge clk) begin
        sd_a <= rst_a_n ? s_a : -1;
        s_a  <= !rst_a_n ? -1 : (s_a < 0 ? 1 : s_a + 1);
        sd_b <= rst_b_n ? s_b : -1;
        s_b  <= !rst_b_n ? -1 : (s_b < 0 ? 1 : s_b + 1);
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        vout_t ea, eb, aa, ab;
        if (s_a != -2) begin
            ea = expect_out(s_a, sd_a, 640, 16, 96, 48, 480, 10, 2, 33);
            aa = '{x: ax, y: ay, hs: ahs, vs: avs, blank: abl, fs: afs, fc: afc};
            checks++;
            if (aa !== ea) begin
                errors++;
                if (errors < 30)
                    $display("FAIL cyc_a s=%0d actual=%h required=%h", s_a, aa, ea);
            end
        end
        if (s_b != -2) begin
            eb = expect_out(s_b, sd_b, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB);
            ab = '{x: bx, y: by, hs: bhs, vs: bvs, blank: bbl, fs: bfs, fc: bfc};
            checks++;
            if (ab !== eb) begin
                errors++;
                if (errors < 30)
                    $display("FAIL cyc_b s=%0d actual=%h required=%h", s_b, ab, eb);
            end
        end
    end

    task automatic pin(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    int tb_b;

    initial begin
        vout_t m;
        // Literal pins on the model itself.
        m = model(419999, 640, 16, 96, 48, 480, 10, 2, 33);
        pin("model_last_x", int'(m.x), 799);
        pin("model_last_y", int'(m.y), 524);
        m = model(420000, 640, 16, 96, 48, 480, 10, 2, 33);
        pin("model_fs", int'(m.fs), 1);
        pin("model_fc", int'(m.fc), 1);
        m = model(490 * 800 + 656, 640, 16, 96, 48, 480, 10, 2, 33);
        pin("model_hs_vs", int'({m.hs, m.vs}), 0);

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        step(10);
        pin("rst_x", int'(ax), 0);
        pin("rst_hs_vs_blank", int'({ahs, avs, abl}), 3'b110);
        pin("rst_fc", int'(afc), 0);

        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        step(1);
        tb_b = 1;
        pin("rel_x", int'(ax), 1);
        pin("rel_y", int'(ay), 0);
        pin("rel_blank", int'(abl), 1 - DLY);
        step(639); tb_b += 639;
        pin("x640", int'(ax), 640);
        pin("blank640", int'(abl), DLY);
        step(16); tb_b += 16;
        pin("hs656", int'(ahs), DLY);
        step(1); tb_b += 1;
        pin("hs657", int'(ahs), 0);
        step(94); tb_b += 94;
        pin("hs751", int'(ahs), 0);
        step(1); tb_b += 1;
        pin("hs752", int'(ahs), 1 - DLY);
        step(47); tb_b += 47;
        pin("x799", int'(ax), 799);
        step(1); tb_b += 1;
        pin("wrap_x", int'(ax), 0);
        pin("wrap_y", int'(ay), 1);
        // Small instance at 800 cycles: frame 4, offset 20 -> (5,1).
        pin("b800_x", int'(bx), 5);
        pin("b800_y", int'(by), 1);
        pin("b800_fc", int'(bfc), 4);

        // Mid-line reset inside hsync on the full-size instance.
        step(1500); tb_b += 1500;
        pin("mid_x", int'(ax), 700);
        pin("mid_y", int'(ay), 2);
        pin("mid_hs", int'(ahs), 0);
        rst_a_n = 1'b0;
        step(1); tb_b += 1;
        pin("mrst_xy", int'({ax, ay}), 0);
        pin("mrst_hs_blank", int'({ahs, abl}), 2'b10);
        pin("mrst_fc", int'(afc), 0);
        rst_a_n = 1'b1;
        step(1); tb_b += 1;
        pin("mrel_x", int'(ax), 1);
        pin("mrel_y", int'(ay), 0);

        // Frame counter wrap on the small instance.
        step(195 * 255 - tb_b); tb_b = 195 * 255;
        pin("b255_fs", int'(bfs), 1);
        pin("b255_fc", int'(bfc), 255);
        step(194); tb_b += 194;
        pin("b_pre_fs", int'(bfs), 0);
        pin("b_pre_fc", int'(bfc), 255);
        step(1); tb_b += 1;
        pin("b_wrap_fs", int'(bfs), 1);
        pin("b_wrap_fc", int'(bfc), 0);
        pin("b_wrap_xy", int'({bx, by}), 0);

        // Reset inside vsync/hsync on the small instance: (10,8).
        step(130);
        pin("b_mid_vs", int'(bvs), 0);
        pin("b_mid_hs", int'(bhs), 0);
        rst_b_n = 1'b0;
        step(1);
        pin("b_mrst_xy", int'({bx, by}), 0);
        pin("b_mrst_fc", int'(bfc), 0);
        rst_b_n = 1'b1;
        step(2);
        pin("b_mrel_x", int'(bx), 2);
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
